ps2_kbd_rx: RTL and testbench

Receives the serial PS/2 keyboard stream that the MiST IO controller block emits on `ps2_kbd_clk`/`ps2_kbd_data` and turns it into decoded key events for the core. It deframes and checks each 11-bit frame and folds the `E0` (extended) and `F0` (break) prefixes into flags on the following scancode. Events are buffered in a small FIFO with a valid/ready handshake. It sits directly downstream of the IO block, inside the core's `clk_sys` domain.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_evt_fifo.sv | 54 +++++
 rtl/ps2_kbd_rx.sv | 195 +++++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_rx_state_t;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_REL = 8'hF0;

    // "release" is a reserved word, so the break flag is called rel.
    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } ps2_key_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through FIFO of decoded key events with a drop strobe.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned AW = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  ps2_key_evt_t i_evt,
    input  logic         i_pop,
    output ps2_key_evt_t o_evt,
    output logic         o_empty,
    output logic         o_drop
);

    localparam int unsigned Depth  = 1 << AW;
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    ps2_key_evt_t r_mem [Depth];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_full;
    logic         w_pop;
    logic         w_push_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop     = i_pop && !o_empty;
    // A pop in the same cycle frees the slot the push is about to take.
    assign w_push_ok = i_push && (!w_full || w_pop);
    assign o_drop    = i_push && w_full && !w_pop;
    assign o_evt     = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_evt;
                r_wr_ptr                <= r_wr_ptr + PtrOne;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrOne;
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames, folds E0/F0 prefixes into
// flags on the following scancode and queues the resulting key events.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT = 20000,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       ps2_kbd_clk,
    input  logic       ps2_kbd_data,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       frame_err,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int unsigned   CntW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic [1:0]      r_clk_sync;
    logic [1:0]      r_dat_sync;
    logic            r_clk_prev;
    logic            w_fall;
    logic            w_bit;

    ps2_rx_state_t   r_state,  w_state_d;
    logic [2:0]      r_bit_idx, w_bit_idx_d;
    logic [7:0]      r_shift,  w_shift_d;
    logic            r_parity, w_parity_d;
    logic [CntW-1:0] r_cnt,    w_cnt_d;
    logic            r_byte_done, w_byte_done_d;
    logic            r_frame_err, w_frame_err_d;

    logic            r_ext_pend;
    logic            r_rel_pend;
    logic            r_overflow;
    logic            w_is_ext;
    logic            w_is_rel;
    logic            w_push;
    logic            w_empty;
    logic            w_drop;
    ps2_key_evt_t    w_evt_in;
    ps2_key_evt_t    w_evt_head;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_kbd_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_kbd_data};
            r_clk_prev <= r_clk_sync[1];
        end
    end

    assign w_fall = r_clk_prev && !r_clk_sync[1];
    assign w_bit  = r_dat_sync[1];

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_cnt       <= '0;
            r_byte_done <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_bit_idx   <= w_bit_idx_d;
            r_shift     <= w_shift_d;
            r_parity    <= w_parity_d;
            r_cnt       <= w_cnt_d;
            r_byte_done <= w_byte_done_d;
            r_frame_err <= w_frame_err_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_bit_idx_d   = r_bit_idx;
        w_shift_d     = r_shift;
        w_parity_d    = r_parity;
        w_cnt_d       = '0;
        w_byte_done_d = 1'b0;
        w_frame_err_d = 1'b0;

        // Watchdog for a stalled frame; any falling edge restarts it.
        if (r_state != StIdle && !w_fall) begin
            if (r_cnt == CntLast) begin
                w_state_d     = StIdle;
                w_shift_d     = '0;
                w_frame_err_d = 1'b1;
            end else begin
                w_cnt_d = r_cnt + CntOne;
            end
        end

        if (w_fall) begin
            case (r_state)
                StIdle: begin
                    if (!w_bit) begin
                        w_state_d   = StData;
                        w_bit_idx_d = '0;
                    end
                end
                StData: begin
                    w_shift_d = {w_bit, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_d = StParity;
                    end else begin
                        w_bit_idx_d = r_bit_idx + 3'd1;
                    end
                end
                StParity: begin
                    w_parity_d = w_bit;
                    w_state_d  = StStop;
                end
                StStop: begin
                    if (w_bit && ((^r_shift) ^ r_parity)) begin
                        w_byte_done_d = 1'b1;
                    end else begin
                        w_frame_err_d = 1'b1;
                    end
                    w_state_d = StIdle;
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    // r_shift is stable while r_byte_done is high: the FSM is back in idle.
    assign w_is_ext = (r_shift == PS2_PFX_EXT);
    assign w_is_rel = (r_shift == PS2_PFX_REL);
    assign w_push   = r_byte_done && !w_is_ext && !w_is_rel;
    assign w_evt_in = '{ext: r_ext_pend, rel: r_rel_pend, code: r_shift};

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_ext_pend <= 1'b0;
            r_rel_pend <= 1'b0;
        end else if (r_frame_err) begin
            r_ext_pend <= 1'b0;
            r_rel_pend <= 1'b0;
        end else if (r_byte_done) begin
            if (w_is_ext) begin
                r_ext_pend <= 1'b1;
            end else if (w_is_rel) begin
                r_rel_pend <= 1'b1;
            end else begin
                r_ext_pend <= 1'b0;
                r_rel_pend <= 1'b0;
            end
        end
    end

    ps2_evt_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .i_clk   (clk_sys),
        .i_rst_n (rst_n),
        .i_push  (w_push),
        .i_evt   (w_evt_in),
        .i_pop   (key_ready),
        .o_evt   (w_evt_head),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign key_valid   = !w_empty;
    assign key_code    = w_evt_head.code;
    assign key_ext     = w_evt_head.ext;
    assign key_release = w_evt_head.rel;
    assign frame_err   = r_frame_err;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: framing, prefixes, errors, timeout, FIFO and reset.
module tb_ps2_kbd_rx;
    import ps2_pkg::*;

    localparam int unsigned Timeout = 200;
    // PS/2 half-bit in clk_sys cycles; a bit period of 80 cycles keeps the 64x margin.
    localparam int unsigned Half    = 40;

    logic       clk_sys      = 1'b0;
    logic       rst_n        = 1'b0;
    logic       ps2_kbd_clk  = 1'b1;
    logic       ps2_kbd_data = 1'b1;
    logic       key_ready    = 1'b0;
    logic       ovf_clr      = 1'b0;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       frame_err;
    logic       overflow;

    int n_checks    = 0;
    int n_fail      = 0;
    int n_err_pulse = 0;
    int err0;

    ps2_kbd_rx #(
        .TIMEOUT (Timeout),
        .FIFO_AW (2)
    ) dut (
        .clk_sys      (clk_sys),
        .rst_n        (rst_n),
        .ps2_kbd_clk  (ps2_kbd_clk),
        .ps2_kbd_data (ps2_kbd_data),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .key_release  (key_release),
        .frame_err    (frame_err),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (frame_err) n_err_pulse++;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_kbd_data = b;
        wait_cyc(Half);
        ps2_kbd_clk = 1'b0;
        wait_cyc(Half);
        ps2_kbd_clk = 1'b1;
    endtask

    // Everything up to and including the stop-bit falling edge.
    task automatic frame_head(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~(^b) ^ bad_par);
        ps2_kbd_data = 1'b1;
        wait_cyc(Half);
        ps2_kbd_clk = 1'b0;
    endtask

    task automatic frame_tail();
        wait_cyc(Half);
        ps2_kbd_clk = 1'b1;
        wait_cyc(Half);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        frame_head(b, bad_par);
        frame_tail();
    endtask

    task automatic pop_check(input string tag, input logic [7:0] code, input logic ext,
                             input logic rel);
        check_eq({tag, "_valid"}, 32'(key_valid), 1);
        check_eq({tag, "_code"}, 32'(key_code), 32'(code));
        check_eq({tag, "_ext"}, 32'(key_ext), 32'(ext));
        check_eq({tag, "_rel"}, 32'(key_release), 32'(rel));
        key_ready = 1'b1;
        wait_cyc(1);
        key_ready = 1'b0;
    endtask

    initial begin
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(3);
        check_eq("rst_valid", 32'(key_valid), 0);
        check_eq("rst_code", 32'(key_code), 0);
        check_eq("rst_ext", 32'(key_ext), 0);
        check_eq("rst_rel", 32'(key_release), 0);
        check_eq("rst_ferr", 32'(frame_err), 0);
        check_eq("rst_ovf", 32'(overflow), 0);

        // 0x1C with the consumer always ready: valid exactly 4 cycles after the stop edge.
        key_ready = 1'b1;
        frame_head(8'h1C, 1'b0);
        wait_cyc(3);
        check_eq("lat_valid_c3", 32'(key_valid), 0);
        check_eq("lat_ferr_c3", 32'(frame_err), 0);
        wait_cyc(1);
        check_eq("lat_valid_c4", 32'(key_valid), 1);
        check_eq("lat_code", 32'(key_code), 'h1C);
        check_eq("lat_ext", 32'(key_ext), 0);
        check_eq("lat_rel", 32'(key_release), 0);
        wait_cyc(1);
        check_eq("lat_valid_popped", 32'(key_valid), 0);
        key_ready = 1'b0;
        frame_tail();

        send_byte(8'hF0, 1'b0);
        check_eq("f0_no_event", 32'(key_valid), 0);
        send_byte(8'h1C, 1'b0);
        pop_check("brk_1c", 8'h1C, 1'b0, 1'b1);
        check_eq("brk_empty", 32'(key_valid), 0);

        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        check_eq("e0f0_no_event", 32'(key_valid), 0);
        send_byte(8'h75, 1'b0);
        pop_check("extbrk_75", 8'h75, 1'b1, 1'b1);
        check_eq("extbrk_empty", 32'(key_valid), 0);
        check_eq("good_no_err", 32'(n_err_pulse), 0);

        // Parity error after E0 must also drop the pending extended flag.
        err0 = n_err_pulse;
        send_byte(8'hE0, 1'b0);
        frame_head(8'h75, 1'b1);
        wait_cyc(3);
        check_eq("par_ferr_c3", 32'(frame_err), 1);
        wait_cyc(1);
        check_eq("par_ferr_c4", 32'(frame_err), 0);
        check_eq("par_no_event", 32'(key_valid), 0);
        frame_tail();
        check_eq("par_err_count", 32'(n_err_pulse - err0), 1);
        send_byte(8'h75, 1'b0);
        pop_check("after_par_75", 8'h75, 1'b0, 1'b0);

        // Abandoned frame: start bit plus 4 data bits, then silence.
        err0 = n_err_pulse;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        wait_cyc(Timeout + 20);
        check_eq("to_err_count", 32'(n_err_pulse - err0), 1);
        check_eq("to_fsm_idle", 32'(dut.r_state), 32'(StIdle));
        check_eq("to_no_event", 32'(key_valid), 0);
        send_byte(8'h29, 1'b0);
        pop_check("after_to_29", 8'h29, 1'b0, 1'b0);

        // Overflow: five codes into a four-deep FIFO.
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
        check_eq("ovf_set", 32'(overflow), 1);
        for (int i = 1; i <= 4; i++) pop_check("ovf_drain", 8'(i), 1'b0, 1'b0);
        check_eq("ovf_empty", 32'(key_valid), 0);
        check_eq("ovf_sticky", 32'(overflow), 1);
        ovf_clr = 1'b1;
        wait_cyc(1);
        ovf_clr = 1'b0;
        check_eq("ovf_cleared", 32'(overflow), 0);

        // Fill, then land a pop on the exact push cycle of the fifth code.
        for (int i = 6; i <= 9; i++) send_byte(8'(i), 1'b0);
        check_eq("full_no_ovf", 32'(overflow), 0);
        frame_head(8'h0A, 1'b0);
        wait_cyc(3);
        key_ready = 1'b1;
        wait_cyc(1);
        key_ready = 1'b0;
        check_eq("pushpop_no_ovf", 32'(overflow), 0);
        frame_tail();
        for (int i = 7; i <= 10; i++) pop_check("pushpop_drain", 8'(i), 1'b0, 1'b0);
        check_eq("pushpop_empty", 32'(key_valid), 0);

        // Reset in the middle of a frame while the FIFO holds an event.
        send_byte(8'h33, 1'b0);
        check_eq("pre_rst_valid", 32'(key_valid), 1);
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(i[0]);
        rst_n = 1'b0;
        #2;
        check_eq("midrst_valid", 32'(key_valid), 0);
        check_eq("midrst_code", 32'(key_code), 0);
        check_eq("midrst_ext", 32'(key_ext), 0);
        check_eq("midrst_rel", 32'(key_release), 0);
        check_eq("midrst_ferr", 32'(frame_err), 0);
        check_eq("midrst_ovf", 32'(overflow), 0);
        ps2_kbd_data = 1'b1;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(5);
        send_byte(8'h5A, 1'b0);
        pop_check("after_rst_5a", 8'h5A, 1'b0, 1'b0);
        check_eq("after_rst_empty", 32'(key_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
